// File: rtl/exe_unit_w38.sv
// exe_unit_w38: registered four-function execution unit (SET, SHIFT,
// signed COMPARE, two's-complement to sign-magnitude CHANGE) on M-bit operands.
// One-cycle latency; result and 4-bit status {ERR, OVF, ZERO, PARITY} are
// registered and cleared asynchronously while i_reset is low.
// Optional feature macro: EXE_UNIT_PARITY_EN (when undefined, o_stat[0] is 0).
module exe_unit_w38 #(
    parameter int M = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [1:0]   i_op,
    input  logic [M-1:0] i_argA,
    input  logic [M-1:0] i_argB,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_stat
);

    localparam logic [1:0] OP_SET     = 2'b00;
    localparam logic [1:0] OP_SHIFT   = 2'b01;
    localparam logic [1:0] OP_COMPARE = 2'b10;
    localparam logic [1:0] OP_CHANGE  = 2'b11;

    localparam logic [M-1:0] WIDTH_VAL = M'(M);
    localparam logic [M-1:0] MOST_NEG  = {1'b1, {(M-1){1'b0}}};

    logic [M-1:0]   bit_sel;
    logic           b_in_range;
    logic [2*M-1:0] shift_wide;
    logic [M-2:0]   magnitude;
    logic           a_gt_b;

    logic [M-1:0]   result_next;
    logic [3:0]     stat_next;
    logic [M-1:0]   result_reg;
    logic [3:0]     stat_reg;

    // B doubles as a bit index / shift count; anything >= M is invalid.
    assign b_in_range = (i_argB < WIDTH_VAL);

    // One-hot decode of B for SET; all zeros when B is out of range.
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_bit_sel
            assign bit_sel[gi] = (i_argB == M'(gi));
        end
    endgenerate

    // Double-width shift keeps the bits pushed past the MSB so OVF can see them.
    assign shift_wide = {{M{1'b0}}, i_argA} << i_argB;

    // Magnitude of a negative A; only the low M-1 bits are ever needed.
    assign magnitude = (~i_argA[M-2:0]) + (M-1)'(1);

    assign a_gt_b = ($signed(i_argA) > $signed(i_argB));

    // Combinational result and flags for the selected operation.
    always_comb begin
        logic err;
        logic ovf;
        logic parity;
        err         = 1'b0;
        ovf         = 1'b0;
        parity      = 1'b0;
        result_next = '0;
        case (i_op)
            OP_SET: begin
                err         = ~b_in_range;
                result_next = i_argA | bit_sel;
            end
            OP_SHIFT: begin
                err         = ~b_in_range;
                result_next = shift_wide[M-1:0];
                ovf         = |shift_wide[2*M-1:M];
            end
            OP_COMPARE: begin
                result_next = {{(M-1){1'b0}}, a_gt_b};
            end
            OP_CHANGE: begin
                err         = (i_argA == MOST_NEG);
                result_next = i_argA[M-1] ? {1'b1, magnitude} : i_argA;
            end
            default: begin
                result_next = '0;
            end
        endcase
`ifdef EXE_UNIT_PARITY_EN
        parity = ^result_next;
`endif
        if (err) begin
            result_next = '0;
            stat_next   = 4'b1000;
        end else begin
            stat_next   = {1'b0, ovf, ~|result_next, parity};
        end
    end

    // Output registers: capture every cycle, cleared asynchronously on reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            result_reg <= '0;
            stat_reg   <= '0;
        end else begin
            result_reg <= result_next;
            stat_reg   <= stat_next;
        end
    end

    assign o_result = result_reg;
    assign o_stat   = stat_reg;

endmodule

// File: tb/tb_exe_unit_w38.sv
// Testbench for exe_unit_w38: directed vector table, reset sequence,
// and back-to-back randomized operations against an arithmetic model.
module tb_exe_unit_w38;

    localparam int M = 8;

    logic         clk;
    logic         rst_n;
    logic [1:0]   op;
    logic [M-1:0] arg_a;
    logic [M-1:0] arg_b;
    logic [M-1:0] result;
    logic [3:0]   stat;

    int checks   = 0;
    int failures = 0;

    exe_unit_w38 #(.M(M)) dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .i_op     (op),
        .i_argA   (arg_a),
        .i_argB   (arg_b),
        .o_result (result),
        .o_stat   (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [M-1:0] res;
        logic [3:0]   stat;
    } vec_t;

    vec_t vecs[14];

    // Parity flag only exists when the feature macro is defined.
    function automatic logic [3:0] build_stat(input logic [3:0] s);
        logic [3:0] r;
        r = s;
`ifndef EXE_UNIT_PARITY_EN
        r[0] = 1'b0;
`endif
        return r;
    endfunction

    // Reference model computed with plain integer arithmetic.
    function automatic logic [M+3:0] model(input logic [1:0] o, input logic [M-1:0] a, input logic [M-1:0] b);
        int ua, ub, sa, sb, res, prod, ones;
        bit err, ovf;
        ua = int'(a); ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        err = 0; ovf = 0; res = 0;
        case (o)
            2'b00: begin
                if (ub >= M) err = 1;
                else res = ua | (1 << ub);
            end
            2'b01: begin
                if (ub >= M) err = 1;
                else begin
                    prod = ua * (2 ** ub);
                    res  = prod % 256;
                    ovf  = (prod >= 256);
                end
            end
            2'b10: res = (sa > sb) ? 1 : 0;
            default: begin
                if (sa == -128) err = 1;
                else if (sa < 0) res = 128 + (-sa);
                else res = ua;
            end
        endcase
        if (err) return {8'h00, 4'b1000};
        ones = 0;
        for (int i = 0; i < M; i++) ones += (res >> i) & 1;
        return {8'(res), build_stat({1'b0, ovf, (res == 0), (ones % 2 == 1)})};
    endfunction

    task automatic check(input string name, input logic [M-1:0] exp_r, input logic [3:0] exp_s);
        checks++;
        if (result !== exp_r || stat !== exp_s) begin
            failures++;
            $display("FAIL %s: got result=%02h stat=%04b, expected result=%02h stat=%04b",
                     name, result, stat, exp_r, exp_s);
        end else begin
            $display("ok   %s: op=%0d a=%02h b=%02h result=%02h stat=%04b",
                     name, op, arg_a, arg_b, result, stat);
        end
    endtask

    // One transaction: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input logic [1:0] o, input logic [M-1:0] a, input logic [M-1:0] b);
        @(negedge clk);
        op = o; arg_a = a; arg_b = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [M+3:0] exp;
        logic [1:0]   ro;
        logic [M-1:0] ra, rb;

        vecs[0]  = '{2'b00, 8'h07, 8'd0,  8'h07, 4'b0001};
        vecs[1]  = '{2'b00, 8'hB0, 8'd0,  8'hB1, 4'b0000};
        vecs[2]  = '{2'b00, 8'h07, 8'd11, 8'h00, 4'b1000};
        vecs[3]  = '{2'b00, 8'h07, 8'hC1, 8'h00, 4'b1000};
        vecs[4]  = '{2'b01, 8'hC3, 8'd5,  8'h60, 4'b0100};
        vecs[5]  = '{2'b01, 8'h08, 8'd5,  8'h00, 4'b0110};
        vecs[6]  = '{2'b01, 8'h08, 8'hB0, 8'h00, 4'b1000};
        vecs[7]  = '{2'b10, 8'd11, 8'd14, 8'h00, 4'b0010};
        vecs[8]  = '{2'b10, 8'd11, 8'd9,  8'h01, 4'b0001};
        vecs[9]  = '{2'b10, 8'd10, 8'd10, 8'h00, 4'b0010};
        vecs[10] = '{2'b10, 8'h80, 8'h01, 8'h00, 4'b0010};
        vecs[11] = '{2'b11, 8'h89, 8'd0,  8'hF7, 4'b0001};
        vecs[12] = '{2'b11, 8'd120, 8'd0, 8'h78, 4'b0000};
        vecs[13] = '{2'b11, 8'h80, 8'd0,  8'h00, 4'b1000};

        rst_n = 1'b0; op = 2'b11; arg_a = 8'd120; arg_b = 8'd0;
        #12;
        check("reset_state", 8'h00, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors from the test plan, issued back-to-back.
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), vecs[i].res, build_stat(vecs[i].stat));
        end

        // Asynchronous reset while a non-zero result is held.
        apply(2'b11, 8'd120, 8'd0);
        check("pre_reset", 8'h78, build_stat(4'b0000));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 8'h00, 4'b0000);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_held", 8'h00, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        op = 2'b00; arg_a = 8'hB0; arg_b = 8'd0;
        @(posedge clk);
        #1;
        check("first_after_reset", 8'hB1, build_stat(4'b0000));

        // Randomized back-to-back operations against the model.
        for (int i = 0; i < 300; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            apply(ro, ra, rb);
            exp = model(ro, ra, rb);
            check($sformatf("rand%0d", i), exp[M+3:4], exp[3:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
